// File: rtl/mc_bus_responder.sv
// MCU async parallel bus responder: synchronises the bus strobes,
// commits writes to a register file and serves reads (regs or FIFO).
//
// Ports:
//   clock, reset_n      system clock, async active-low reset
//   mc_ce/mc_we/mc_oe   async active-low bus strobes (raw pins)
//   mc_add, mc_data_in  async bus address and write data
//   mc_data_out         registered read data to the pad
//   mc_data_oe          pad driver enable (raw-pin gated)
//   reg_q               flattened register file, reg n at [n*W +: W]
//   wr_strobe           one-cycle pulse per committed register write
//   rd_strobe           one-cycle pulse per started register read
//   fifo_data           FIFO head word
//   fifo_empty          FIFO empty flag
//   fifo_pop            one-cycle pop pulse
//   fifo_underflow      one-cycle pulse on a read of an empty FIFO
//   protocol_error      sticky: we and oe seen low together
module mc_bus_responder #(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6,
    parameter int REG_COUNT     = 8,
    parameter int FIFO_ADDR     = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               mc_ce,
    input  logic                               mc_we,
    input  logic                               mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]            mc_add,
    input  logic [MC_DATA_WIDTH-1:0]           mc_data_in,
    output logic [MC_DATA_WIDTH-1:0]           mc_data_out,
    output logic                               mc_data_oe,
    output logic [REG_COUNT*MC_DATA_WIDTH-1:0] reg_q,
    output logic [REG_COUNT-1:0]               wr_strobe,
    output logic [REG_COUNT-1:0]               rd_strobe,
    input  logic [MC_DATA_WIDTH-1:0]           fifo_data,
    input  logic                               fifo_empty,
    output logic                               fifo_pop,
    output logic                               fifo_underflow,
    output logic                               protocol_error
);

    localparam int W  = MC_DATA_WIDTH;
    localparam int AW = MC_ADD_WIDTH;
    localparam int SS = SYNC_STAGES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [SS-1:0] ce_p, we_p, oe_p;
    logic [AW-1:0] add_p [SS];
    logic [W-1:0]  din_p [SS];

    logic ce_s, we_s, oe_s;
    logic we_d, oe_d;
    logic we_rise, oe_fall, oe_rise;
    logic [AW-1:0] add_s;
    logic [W-1:0]  din_s;

    logic [W-1:0] regs [REG_COUNT];

    logic [REG_COUNT-1:0] addr_hit, wr_hit;
    logic                 is_fifo;
    logic [W-1:0]         rd_word;
    logic                 do_commit, do_read, set_err;

    // Strobes idle high, so the synchronisers reset to 1 to avoid
    // phantom edges right after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ce_p <= '1;
            we_p <= '1;
            oe_p <= '1;
            we_d <= 1'b1;
            oe_d <= 1'b1;
            for (int i = 0; i < SS; i++) begin
                add_p[i] <= '0;
                din_p[i] <= '0;
            end
        end else begin
            ce_p     <= {ce_p[SS-2:0], mc_ce};
            we_p     <= {we_p[SS-2:0], mc_we};
            oe_p     <= {oe_p[SS-2:0], mc_oe};
            we_d     <= we_s;
            oe_d     <= oe_s;
            add_p[0] <= mc_add;
            din_p[0] <= mc_data_in;
            for (int i = 1; i < SS; i++) begin
                add_p[i] <= add_p[i-1];
                din_p[i] <= din_p[i-1];
            end
        end
    end

    assign ce_s    = ce_p[SS-1];
    assign we_s    = we_p[SS-1];
    assign oe_s    = oe_p[SS-1];
    assign add_s   = add_p[SS-1];
    assign din_s   = din_p[SS-1];
    assign we_rise = we_s & ~we_d;
    assign oe_fall = ~oe_s & oe_d;
    assign oe_rise = oe_s & ~oe_d;

    always_comb begin
        addr_hit = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            addr_hit[i] = (add_s == AW'(i));
        end
        is_fifo = (add_s == AW'(FIFO_ADDR));
        wr_hit  = is_fifo ? '0 : addr_hit;
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (addr_hit[i]) rd_word = regs[i];
        end
        if (is_fifo) rd_word = fifo_empty ? '0 : fifo_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // A we/oe overlap overrides every state so a conflicting cycle
    // can neither commit nor read.
    always_comb begin
        state_n   = state;
        do_commit = 1'b0;
        do_read   = 1'b0;
        set_err   = 1'b0;
        if (!we_s && !oe_s) begin
            set_err = 1'b1;
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!we_s && !ce_s) begin
                        state_n = WRITE;
                    end else if (oe_fall && !ce_s) begin
                        state_n = READ;
                        do_read = 1'b1;
                    end
                end
                WRITE: begin
                    if (we_rise) begin
                        do_commit = 1'b1;
                        state_n   = IDLE;
                    end else if (ce_s) begin
                        state_n = IDLE;
                    end
                end
                READ: begin
                    if (oe_rise) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            wr_strobe      <= '0;
            rd_strobe      <= '0;
            mc_data_out    <= '0;
            fifo_pop       <= 1'b0;
            fifo_underflow <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (do_commit && wr_hit[i]) regs[i] <= din_s;
            end
            wr_strobe      <= do_commit ? wr_hit : '0;
            rd_strobe      <= do_read ? addr_hit : '0;
            fifo_pop       <= do_read & is_fifo & ~fifo_empty;
            fifo_underflow <= do_read & is_fifo & fifo_empty;
            if (do_read) mc_data_out    <= rd_word;
            if (set_err) protocol_error <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            reg_q[i*W +: W] = regs[i];
        end
    end

    // Raw pins gate the driver so the pad is released the moment the
    // MCU lets go, without waiting for the synchroniser.
    assign mc_data_oe = (state == READ) & ~mc_ce & ~mc_oe;

endmodule

// File: tb/tb_mc_bus_responder.sv
// Directed testbench for mc_bus_responder.
// Drives bus cycles and checks registers, strobes and read data.
module tb_mc_bus_responder;

    logic         clock;
    logic         reset_n;
    logic         mc_ce, mc_we, mc_oe;
    logic [5:0]   mc_add;
    logic [15:0]  mc_data_in;
    logic [15:0]  mc_data_out;
    logic         mc_data_oe;
    logic [127:0] reg_q;
    logic [7:0]   wr_strobe, rd_strobe;
    logic [15:0]  fifo_data;
    logic         fifo_empty;
    logic         fifo_pop, fifo_underflow, protocol_error;

    int checks = 0;
    int errors = 0;

    int wr_cnt [8];
    int rd_cnt [8];
    int wr_tot = 0, rd_tot = 0;
    int pop_cnt = 0, uf_cnt = 0, oe_bad = 0;

    logic [127:0] exp_q;

    mc_bus_responder dut (
        .clock(clock), .reset_n(reset_n),
        .mc_ce(mc_ce), .mc_we(mc_we), .mc_oe(mc_oe),
        .mc_add(mc_add), .mc_data_in(mc_data_in),
        .mc_data_out(mc_data_out), .mc_data_oe(mc_data_oe),
        .reg_q(reg_q), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_pop(fifo_pop), .fifo_underflow(fifo_underflow),
        .protocol_error(protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 8; i++) begin
            wr_cnt[i] = 0;
            rd_cnt[i] = 0;
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (wr_strobe[i]) begin wr_cnt[i]++; wr_tot++; end
            if (rd_strobe[i]) begin rd_cnt[i]++; rd_tot++; end
        end
        if (fifo_pop) pop_cnt++;
        if (fifo_underflow) uf_cnt++;
        if (mc_data_oe && (mc_oe || mc_ce)) oe_bad++;
    end

    task automatic clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [15:0] d,
                             input int n);
        mc_add = a;
        mc_data_in = d;
        mc_ce = 1'b0;
        clk(1);
        mc_we = 1'b0;
        clk(n);
        mc_we = 1'b1;
        clk(1);
        mc_ce = 1'b1;
        clk(4);
    endtask

    task automatic bus_read(input logic [5:0] a, input int n,
                            output logic [15:0] d,
                            output logic oe_seen,
                            output logic oe_after);
        mc_add = a;
        mc_ce = 1'b0;
        clk(1);
        mc_oe = 1'b0;
        clk(n);
        @(negedge clock);
        d = mc_data_out;
        oe_seen = mc_data_oe;
        clk(1);
        mc_oe = 1'b1;
        #1;
        oe_after = mc_data_oe;
        clk(1);
        mc_ce = 1'b1;
        clk(4);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
        mc_add = '0; mc_data_in = '0;
        fifo_data = '0; fifo_empty = 1'b1;
        exp_q = '0;
        clk(3);
        reset_n = 1'b1;
        clk(2);
        @(negedge clock);
        checks++;
        if (reg_q !== 128'h0) begin
            errors++;
            $display("FAIL reset_reg_q: got %h want 0", reg_q);
        end
        checks++;
        if (mc_data_out !== 16'h0 || mc_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got %h/%b want 0/0",
                     mc_data_out, mc_data_oe);
        end
        checks++;
        if ({wr_strobe, rd_strobe, fifo_pop, fifo_underflow,
             protocol_error} !== 19'h0) begin
            errors++;
            $display("FAIL reset_flags: got %h/%h/%b/%b/%b want 0",
                     wr_strobe, rd_strobe, fifo_pop,
                     fifo_underflow, protocol_error);
        end
    endtask

    task automatic test_write;
        int w0, t0;
        w0 = wr_cnt[0];
        t0 = wr_tot;
        mc_add = 6'd0;
        mc_data_in = 16'h00FB;
        mc_ce = 1'b0;
        clk(1);
        mc_we = 1'b0;
        clk(6);
        mc_we = 1'b1;
        clk(2);
        @(negedge clock);
        checks++;
        if (reg_q[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL write_early: got %h want 0000", reg_q[15:0]);
        end
        clk(1);
        exp_q[15:0] = 16'h00FB;
        checks++;
        if (reg_q !== exp_q) begin
            errors++;
            $display("FAIL write_latency: got %h want %h", reg_q, exp_q);
        end
        clk(1);
        mc_ce = 1'b1;
        clk(4);
        checks++;
        if (wr_cnt[0] - w0 !== 1 || wr_tot - t0 !== 1) begin
            errors++;
            $display("FAIL write_strobe: got %0d/%0d want 1/1",
                     wr_cnt[0] - w0, wr_tot - t0);
        end
    endtask

    task automatic test_write_read;
        logic [15:0] d;
        logic os, oa;
        int r1, rt, ob;
        bus_write(6'd1, 16'h0004, 6);
        exp_q[31:16] = 16'h0004;
        checks++;
        if (reg_q !== exp_q) begin
            errors++;
            $display("FAIL wr1_reg_q: got %h want %h", reg_q, exp_q);
        end
        r1 = rd_cnt[1];
        rt = rd_tot;
        ob = oe_bad;
        bus_read(6'd1, 6, d, os, oa);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL rd1_data: got %h want 0004", d);
        end
        checks++;
        if (os !== 1'b1 || oa !== 1'b0) begin
            errors++;
            $display("FAIL rd1_oe: got %b/%b want 1/0", os, oa);
        end
        checks++;
        if (rd_cnt[1] - r1 !== 1 || rd_tot - rt !== 1) begin
            errors++;
            $display("FAIL rd1_strobe: got %0d/%0d want 1/1",
                     rd_cnt[1] - r1, rd_tot - rt);
        end
        checks++;
        if (oe_bad != ob || mc_data_out !== 16'h0004) begin
            errors++;
            $display("FAIL rd1_hold: got %0d/%h want %0d/0004",
                     oe_bad, mc_data_out, ob);
        end
    endtask

    task automatic test_fifo;
        logic [15:0] d;
        logic os, oa;
        int p0, u0, r2;
        fifo_data = 16'h00AA;
        fifo_empty = 1'b0;
        p0 = pop_cnt; u0 = uf_cnt; r2 = rd_cnt[2];
        bus_read(6'd2, 6, d, os, oa);
        checks++;
        if (d !== 16'h00AA) begin
            errors++;
            $display("FAIL fifo_data: got %h want 00AA", d);
        end
        checks++;
        if (pop_cnt - p0 !== 1 || uf_cnt - u0 !== 0) begin
            errors++;
            $display("FAIL fifo_pop: got %0d/%0d want 1/0",
                     pop_cnt - p0, uf_cnt - u0);
        end
        checks++;
        if (rd_cnt[2] - r2 !== 1) begin
            errors++;
            $display("FAIL fifo_rdstb: got %0d want 1", rd_cnt[2] - r2);
        end
        fifo_empty = 1'b1;
        p0 = pop_cnt; u0 = uf_cnt;
        bus_read(6'd2, 6, d, os, oa);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL fifo_empty_data: got %h want 0000", d);
        end
        checks++;
        if (pop_cnt - p0 !== 0 || uf_cnt - u0 !== 1) begin
            errors++;
            $display("FAIL fifo_underflow: got %0d/%0d want 0/1",
                     pop_cnt - p0, uf_cnt - u0);
        end
    endtask

    task automatic test_ignored;
        logic [15:0] d;
        logic os, oa;
        int t0, rt;
        t0 = wr_tot;
        bus_write(6'h3F, 16'h1234, 6);
        bus_write(6'd2, 16'h1234, 6);
        checks++;
        if (reg_q !== exp_q || wr_tot - t0 !== 0) begin
            errors++;
            $display("FAIL ign_write: got %h/%0d want %h/0",
                     reg_q, wr_tot - t0, exp_q);
        end
        bus_read(6'd1, 6, d, os, oa);
        rt = rd_tot;
        bus_read(6'h3F, 6, d, os, oa);
        checks++;
        if (d !== 16'h0000 || rd_tot - rt !== 0) begin
            errors++;
            $display("FAIL ign_read: got %h/%0d want 0000/0",
                     d, rd_tot - rt);
        end
    endtask

    task automatic test_protocol_error;
        int t0, rt, p0;
        t0 = wr_tot; rt = rd_tot;
        mc_add = 6'd0;
        mc_data_in = 16'h5555;
        mc_ce = 1'b0;
        clk(1);
        mc_we = 1'b0;
        mc_oe = 1'b0;
        clk(6);
        mc_we = 1'b1;
        mc_oe = 1'b1;
        clk(1);
        mc_ce = 1'b1;
        clk(4);
        checks++;
        if (protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL perr_set: got %b want 1", protocol_error);
        end
        checks++;
        if (reg_q !== exp_q || wr_tot - t0 !== 0 || rd_tot - rt !== 0)
        begin
            errors++;
            $display("FAIL perr_nocommit: got %h/%0d/%0d want %h/0/0",
                     reg_q, wr_tot - t0, rd_tot - rt, exp_q);
        end
        fifo_empty = 1'b0;
        fifo_data = 16'h0077;
        p0 = pop_cnt;
        mc_add = 6'd2;
        mc_ce = 1'b0;
        clk(1);
        mc_we = 1'b0;
        mc_oe = 1'b0;
        clk(6);
        mc_we = 1'b1;
        mc_oe = 1'b1;
        clk(1);
        mc_ce = 1'b1;
        clk(4);
        checks++;
        if (pop_cnt - p0 !== 0) begin
            errors++;
            $display("FAIL perr_nopop: got %0d want 0", pop_cnt - p0);
        end
        bus_write(6'd3, 16'h0033, 6);
        exp_q[63:48] = 16'h0033;
        checks++;
        if (reg_q !== exp_q || protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky: got %h/%b want %h/1",
                     reg_q, protocol_error, exp_q);
        end
    endtask

    task automatic test_reset_abort;
        int t0, w0, p0, k;
        t0 = wr_tot;
        mc_add = 6'd0;
        mc_data_in = 16'h8000;
        mc_ce = 1'b0;
        clk(1);
        mc_we = 1'b0;
        clk(4);
        #2;
        reset_n = 1'b0;
        mc_we = 1'b1;
        mc_ce = 1'b1;
        clk(3);
        reset_n = 1'b1;
        clk(4);
        exp_q = '0;
        checks++;
        if (reg_q !== exp_q || wr_tot - t0 !== 0) begin
            errors++;
            $display("FAIL rst_abort: got %h/%0d want 0/0",
                     reg_q, wr_tot - t0);
        end
        checks++;
        if (protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_perr_clear: got %b want 0",
                     protocol_error);
        end
        fifo_empty = 1'b0;
        fifo_data = 16'h00BB;
        p0 = pop_cnt;
        mc_add = 6'd2;
        mc_ce = 1'b0;
        clk(1);
        mc_oe = 1'b0;
        #2;
        reset_n = 1'b0;
        mc_oe = 1'b1;
        mc_ce = 1'b1;
        clk(2);
        reset_n = 1'b1;
        clk(4);
        checks++;
        if (pop_cnt - p0 !== 0) begin
            errors++;
            $display("FAIL rst_nopop: got %0d want 0", pop_cnt - p0);
        end
        mc_add = 6'd1;
        mc_ce = 1'b0;
        clk(1);
        mc_oe = 1'b0;
        k = 0;
        while (mc_data_oe !== 1'b1 && k < 10) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (mc_data_oe !== 1'b1) begin
            errors++;
            $display("FAIL rst_rd_start: got %b want 1", mc_data_oe);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mc_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL rst_oe_drop: got %b want 0", mc_data_oe);
        end
        mc_oe = 1'b1;
        mc_ce = 1'b1;
        clk(2);
        reset_n = 1'b1;
        clk(4);
        w0 = wr_cnt[0];
        bus_write(6'd0, 16'h8000, 6);
        exp_q[15:0] = 16'h8000;
        checks++;
        if (reg_q !== exp_q || wr_cnt[0] - w0 !== 1) begin
            errors++;
            $display("FAIL rst_clean_write: got %h/%0d want %h/1",
                     reg_q, wr_cnt[0] - w0, exp_q);
        end
        checks++;
        if (oe_bad !== 0) begin
            errors++;
            $display("FAIL oe_window: got %0d want 0", oe_bad);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_read();
        test_fifo();
        test_ignored();
        test_protocol_error();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
